// File: rtl/serial_copy_engine.sv
// ROM-to-RAM copy engine: words are fetched from a sync ROM, sent as framed serial words,
// and the frames arriving on rx_serial are rebuilt and written into a RAM.
//
// tx state  | meaning
// TX_IDLE   | waiting for an accepted start with a nonzero word count
// TX_FETCH  | rom_addr presented to the ROM
// TX_LOAD   | rom_data captured into the shift register
// TX_START  | start bit (0)
// TX_DATA   | data bits, LSB first
// TX_PARITY | even-parity bit (only when PARITY_EN)
// TX_STOP   | stop bit (1), then next word or TX_END
// TX_END    | all words sent, waiting for the receiver to finish
//
// rx state  | meaning
// RX_IDLE   | waiting for a falling edge while busy
// RX_BITS   | sampling data, parity and stop bits mid-period
// RX_WRITE  | one-cycle RAM write of the rebuilt word
module serial_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int BIT_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  tx_serial,
  input  logic                  rx_serial,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int TW = $clog2(2 * BIT_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH + PARITY_EN + 2);
  localparam logic [TW-1:0] BIT_LAST     = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] FIRST_SAMPLE = TW'(BIT_DIV / 2 + BIT_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST    = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] DATA_N       = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] STOP_IDX     = BW'(DATA_WIDTH + PARITY_EN);
  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_FETCH, TX_LOAD, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_END
  } tx_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_WRITE} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  rx_state_t rx_state, rx_state_n;

  logic                  accept, launch;
  logic [TW-1:0]         tx_tmr, rx_tmr;
  logic                  tx_tmr_zero, rx_tmr_zero, tx_bit_state;
  logic [BW-1:0]         tx_idx, rx_idx;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;
  logic                  tx_par, rx_par;
  logic [ADDR_WIDTH:0]   tx_left, rx_left;

  assign accept       = start && !busy;
  assign launch       = accept && (word_count != '0);
  assign tx_tmr_zero  = (tx_tmr == '0);
  assign rx_tmr_zero  = (rx_tmr == '0);
  assign tx_bit_state = (tx_state == TX_START) || (tx_state == TX_DATA) ||
                        (tx_state == TX_PARITY) || (tx_state == TX_STOP);

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      TX_IDLE:   if (launch) tx_state_n = TX_FETCH;
      TX_FETCH:  tx_state_n = TX_LOAD;
      TX_LOAD:   tx_state_n = TX_START;
      TX_START:  if (tx_tmr_zero) tx_state_n = TX_DATA;
      TX_DATA:   if (tx_tmr_zero && tx_idx == DATA_LAST)
                   tx_state_n = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_tmr_zero) tx_state_n = TX_STOP;
      TX_STOP:   if (tx_tmr_zero) tx_state_n = (tx_left == ONE_WORD) ? TX_END : TX_FETCH;
      TX_END:    if (launch) tx_state_n = TX_FETCH;
                 else if (!busy) tx_state_n = TX_IDLE;
      default:   tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    case (tx_state)
      TX_START:  tx_serial = 1'b0;
      TX_DATA:   tx_serial = tx_shift[0];
      TX_PARITY: tx_serial = tx_par;
      default:   tx_serial = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      tx_left  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_idx   <= '0;
      tx_tmr   <= '0;
    end else begin
      // bit timer reloads at the start of every bit period
      if (!tx_bit_state || tx_tmr_zero) tx_tmr <= BIT_LAST;
      else                              tx_tmr <= tx_tmr - 1'b1;
      if (launch) begin
        rom_addr <= '0;
        tx_left  <= word_count;
      end
      if (tx_state == TX_LOAD) begin
        tx_shift <= rom_data;
        tx_par   <= ^rom_data;
        tx_idx   <= '0;
      end
      if (tx_state == TX_DATA && tx_tmr_zero) begin
        tx_shift <= tx_shift >> 1;
        tx_idx   <= tx_idx + 1'b1;
      end
      if (tx_state == TX_STOP && tx_tmr_zero) begin
        tx_left <= tx_left - 1'b1;
        if (tx_left != ONE_WORD) rom_addr <= rom_addr + 1'b1;
      end
    end
  end

  // ---------------- receive FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (busy && !rx_serial) rx_state_n = RX_BITS;
      RX_BITS:  if (rx_tmr_zero && rx_idx == STOP_IDX) rx_state_n = RX_WRITE;
      RX_WRITE: rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_comb begin
    ram_we = (rx_state == RX_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr   <= '0;
      ram_data   <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_idx     <= '0;
      rx_tmr     <= '0;
      rx_left    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        ram_addr   <= '0;
        rx_left    <= word_count;
        if (word_count == '0) done <= 1'b1;
        else                  busy <= 1'b1;
      end
      case (rx_state)
        // the cycle the falling edge is seen is offset 0 of the start bit
        RX_IDLE: begin
          rx_tmr <= FIRST_SAMPLE;
          rx_idx <= '0;
          rx_par <= 1'b0;
        end
        RX_BITS: begin
          if (rx_tmr_zero) begin
            rx_tmr <= BIT_LAST;
            rx_idx <= rx_idx + 1'b1;
            if (rx_idx < DATA_N) rx_shift <= {rx_serial, rx_shift[DATA_WIDTH-1:1]};
            if (rx_idx != STOP_IDX) begin
              rx_par <= rx_par ^ rx_serial;
            end else begin
              ram_data <= rx_shift;
              if (!rx_serial) frame_err <= 1'b1;
              if (PARITY_EN != 0 && rx_par) parity_err <= 1'b1;
            end
          end else begin
            rx_tmr <= rx_tmr - 1'b1;
          end
        end
        RX_WRITE: begin
          ram_addr <= ram_addr + 1'b1;
          rx_left  <= rx_left - 1'b1;
          if (rx_left == ONE_WORD) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_copy_engine.sv
// Bench for serial_copy_engine: instance A uses default parameters, instance B runs
// BIT_DIV=4 without parity. tx loops back to rx through a bench-controlled corruption path.
module tb_serial_copy_engine;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int P_A = 1, B_A = 1;
  localparam int P_B = 0, B_B = 4;
  // FETCH + LOAD, then start/data/parity/stop bits of BIT_DIV cycles each
  localparam int PER_A = 2 + (2 + DW + P_A) * B_A;
  localparam int PER_B = 2 + (2 + DW + P_B) * B_B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic          start_a, mark_a, hold_low_a;
  logic [AW:0]   wc_a;
  logic [AW-1:0] rom_addr_a, ram_addr_a;
  logic [DW-1:0] rom_data_a, ram_data_a;
  logic          tx_a, rx_a, ram_we_a, busy_a, done_a, perr_a, ferr_a;
  logic [DW-1:0] rom_a [16];
  logic [DW-1:0] ram_a [16];
  int            cyc_a = 0;
  int            tamper_a = 0;
  int            we_q_a[$];
  int            done_cnt_a, done_cyc_a;
  bit            busy_seen_a, txlow_seen_a;

  assign rx_a = hold_low_a ? 1'b0 : (tx_a ^ (tamper_a != 0 && cyc_a == tamper_a));

  serial_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARITY_EN(P_A), .BIT_DIV(B_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .word_count(wc_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .tx_serial(tx_a), .rx_serial(rx_a),
    .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_we(ram_we_a),
    .busy(busy_a), .done(done_a), .parity_err(perr_a), .frame_err(ferr_a));

  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
  always @(posedge clk) cyc_a <= mark_a ? 1 : cyc_a + 1;

  always @(negedge clk) begin
    if (ram_we_a) begin
      ram_a[ram_addr_a] = ram_data_a;
      we_q_a.push_back(cyc_a);
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc_a;
    end
    if (busy_a) busy_seen_a = 1'b1;
    if (!tx_a) txlow_seen_a = 1'b1;
  end

  // ---------------- instance B ----------------
  logic          start_b, mark_b;
  logic [AW:0]   wc_b;
  logic [AW-1:0] rom_addr_b, ram_addr_b;
  logic [DW-1:0] rom_data_b, ram_data_b;
  logic          tx_b, ram_we_b, busy_b, done_b, perr_b, ferr_b;
  logic [DW-1:0] rom_b [16];
  logic [DW-1:0] ram_b [16];
  int            cyc_b = 0;
  int            we_q_b[$];
  int            done_cnt_b, done_cyc_b;

  serial_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARITY_EN(P_B), .BIT_DIV(B_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .word_count(wc_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .tx_serial(tx_b), .rx_serial(tx_b),
    .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_we(ram_we_b),
    .busy(busy_b), .done(done_b), .parity_err(perr_b), .frame_err(ferr_b));

  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];
  always @(posedge clk) cyc_b <= mark_b ? 1 : cyc_b + 1;

  always @(negedge clk) begin
    if (ram_we_b) begin
      ram_b[ram_addr_b] = ram_data_b;
      we_q_b.push_back(cyc_b);
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc_b;
    end
  end

  // Cycle (counted from the accepting edge = 0) in which word k is written to RAM.
  function automatic int we_cycle(int k, int per, int p, int b);
    return 3 + k * per + (1 + DW + p) * b + b / 2 + 1;
  endfunction

  // ---------------- helpers for stimulus only ----------------
  task automatic launch_a(input int wc, input int tamper);
    @(posedge clk); #1;
    we_q_a.delete();
    done_cnt_a = 0; done_cyc_a = -1; busy_seen_a = 1'b0; txlow_seen_a = 1'b0;
    for (int i = 0; i < 16; i++) ram_a[i] = 'x;
    tamper_a = tamper;
    start_a = 1'b1; mark_a = 1'b1; wc_a = (AW+1)'(wc);
    @(posedge clk); #1;
    start_a = 1'b0; mark_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    int n = 0;
    while (done_cnt_a == 0 && n < limit) begin
      @(posedge clk); n++;
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt_a == 0) begin
      n_err++; $display("FAIL done_timeout_a: no done within %0d cycles", limit);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rom_addr_a, ram_addr_a, ram_data_a, ram_we_a, tx_a, busy_a, done_a, perr_a, ferr_a}
        !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_values_a: got %h %h %h %b%b%b%b%b%b", rom_addr_a, ram_addr_a,
                        ram_data_a, ram_we_a, tx_a, busy_a, done_a, perr_a, ferr_a);
    end
    n_cmp++;
    if ({busy_b, done_b, tx_b, ram_we_b} !== 4'b0010) begin
      n_err++; $display("FAIL reset_values_b: got busy %b done %b tx %b we %b expected 0 0 1 0",
                        busy_b, done_b, tx_b, ram_we_b);
    end
    rst = 1'b0;
    rom_a[0] = 8'hA5; rom_a[1] = 8'h3C; rom_a[2] = 8'hFF; rom_a[3] = 8'h00;
    launch_a(4, 0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rom_addr_a, ram_addr_a, ram_data_a, ram_we_a, tx_a, busy_a, done_a, perr_a, ferr_a}
        !== {4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_midcopy_a: got %h %h %h %b%b%b%b%b%b", rom_addr_a, ram_addr_a,
                        ram_data_a, ram_we_a, tx_a, busy_a, done_a, perr_a, ferr_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt_a !== 0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL reset_abort_a: done pulses %0d busy %b expected 0 0", done_cnt_a, busy_a);
    end
  endtask

  task automatic test_copy(input bit fixed, input int wc);
    if (fixed) begin
      rom_a[0] = 8'hA5; rom_a[1] = 8'h3C; rom_a[2] = 8'hFF; rom_a[3] = 8'h00;
    end else begin
      for (int i = 0; i < 16; i++) rom_a[i] = DW'($urandom);
    end
    launch_a(wc, 0);
    wait_done_a(20 * 16);
    for (int k = 0; k < wc; k++) begin
      n_cmp++;
      if (ram_a[k] !== rom_a[k]) begin
        n_err++; $display("FAIL copy_data[%0d]: got %h expected %h", k, ram_a[k], rom_a[k]);
      end
      n_cmp++;
      if (((k < we_q_a.size()) ? we_q_a[k] : -1) != we_cycle(k, PER_A, P_A, B_A)) begin
        n_err++; $display("FAIL copy_we_cycle[%0d]: got %0d expected %0d", k,
                          (k < we_q_a.size()) ? we_q_a[k] : -1, we_cycle(k, PER_A, P_A, B_A));
      end
    end
    n_cmp++;
    if (we_q_a.size() != wc || done_cnt_a != 1) begin
      n_err++; $display("FAIL copy_counts: we %0d done %0d expected %0d 1", we_q_a.size(), done_cnt_a, wc);
    end
    n_cmp++;
    if (done_cyc_a != we_cycle(wc - 1, PER_A, P_A, B_A) + 1) begin
      n_err++; $display("FAIL copy_done_cycle: got %0d expected %0d", done_cyc_a,
                        we_cycle(wc - 1, PER_A, P_A, B_A) + 1);
    end
    n_cmp++;
    if ({perr_a, ferr_a, busy_a} !== 3'b000 || ram_addr_a !== AW'(wc % 16)) begin
      n_err++; $display("FAIL copy_end_state: perr %b ferr %b busy %b ram_addr %0d expected 0 0 0 %0d",
                        perr_a, ferr_a, busy_a, ram_addr_a, wc % 16);
    end
  endtask

  task automatic test_zero_count;
    launch_a(0, 0);
    wait_done_a(10);
    n_cmp++;
    if (done_cyc_a != 1 || done_cnt_a != 1) begin
      n_err++; $display("FAIL zero_done: cycle %0d count %0d expected 1 1", done_cyc_a, done_cnt_a);
    end
    n_cmp++;
    if (busy_seen_a || txlow_seen_a || we_q_a.size() != 0) begin
      n_err++; $display("FAIL zero_quiet: busy %b txlow %b we %0d expected 0 0 0",
                        busy_seen_a, txlow_seen_a, we_q_a.size());
    end
  endtask

  task automatic test_parity_err;
    for (int i = 0; i < 16; i++) rom_a[i] = DW'($urandom);
    launch_a(4, 3 + PER_A + (1 + DW) * B_A);
    wait_done_a(100);
    n_cmp++;
    if ({perr_a, ferr_a} !== 2'b10 || done_cnt_a != 1) begin
      n_err++; $display("FAIL parity_flags: perr %b ferr %b done %0d expected 1 0 1", perr_a, ferr_a, done_cnt_a);
    end
    n_cmp++;
    if (ram_a[1] !== rom_a[1] || we_q_a.size() != 4) begin
      n_err++; $display("FAIL parity_word_written: ram1 %h we %0d expected %h 4", ram_a[1], we_q_a.size(), rom_a[1]);
    end
    launch_a(2, 0);
    n_cmp++;
    if (perr_a !== 1'b0) begin
      n_err++; $display("FAIL parity_cleared: got %b expected 0", perr_a);
    end
    wait_done_a(100);
    n_cmp++;
    if (perr_a !== 1'b0 || ram_a[1] !== rom_a[1]) begin
      n_err++; $display("FAIL parity_clean_rerun: perr %b ram1 %h expected 0 %h", perr_a, ram_a[1], rom_a[1]);
    end
  endtask

  task automatic test_frame_err;
    for (int i = 0; i < 16; i++) rom_a[i] = DW'($urandom);
    launch_a(4, 3 + (1 + DW + P_A) * B_A);
    repeat (10) @(posedge clk);
    #1;
    start_a = 1'b1; wc_a = (AW+1)'(1);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(100);
    n_cmp++;
    if ({perr_a, ferr_a} !== 2'b01) begin
      n_err++; $display("FAIL frame_flags: perr %b ferr %b expected 0 1", perr_a, ferr_a);
    end
    n_cmp++;
    if (we_q_a.size() != 4 || done_cnt_a != 1 || done_cyc_a != we_cycle(3, PER_A, P_A, B_A) + 1) begin
      n_err++; $display("FAIL frame_busy_start_ignored: we %0d done %0d at %0d expected 4 1 %0d",
                        we_q_a.size(), done_cnt_a, done_cyc_a, we_cycle(3, PER_A, P_A, B_A) + 1);
    end
    n_cmp++;
    if (ram_a[0] !== rom_a[0] || ram_a[3] !== rom_a[3]) begin
      n_err++; $display("FAIL frame_data: got %h %h expected %h %h", ram_a[0], ram_a[3], rom_a[0], rom_a[3]);
    end
  endtask

  task automatic test_idle_glitch;
    @(posedge clk); #1;
    we_q_a.delete(); busy_seen_a = 1'b0;
    hold_low_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold_low_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (we_q_a.size() != 0 || busy_seen_a) begin
      n_err++; $display("FAIL idle_glitch: we %0d busy %b expected 0 0", we_q_a.size(), busy_seen_a);
    end
    for (int i = 0; i < 16; i++) rom_a[i] = DW'($urandom);
    launch_a(2, 0);
    wait_done_a(100);
    n_cmp++;
    if (ram_a[0] !== rom_a[0] || ram_a[1] !== rom_a[1] || ferr_a !== 1'b0) begin
      n_err++; $display("FAIL idle_glitch_recover: got %h %h ferr %b expected %h %h 0",
                        ram_a[0], ram_a[1], ferr_a, rom_a[0], rom_a[1]);
    end
  endtask

  task automatic test_full_depth;
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      rom_b[i] = DW'($urandom);
      ram_b[i] = 'x;
    end
    @(posedge clk); #1;
    we_q_b.delete(); done_cnt_b = 0; done_cyc_b = -1;
    start_b = 1'b1; mark_b = 1'b1; wc_b = (AW+1)'(16);
    @(posedge clk); #1;
    start_b = 1'b0; mark_b = 1'b0;
    while (done_cnt_b == 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt_b != 1 || done_cyc_b != we_cycle(15, PER_B, P_B, B_B) + 1) begin
      n_err++; $display("FAIL full_done: count %0d cycle %0d expected 1 %0d", done_cnt_b, done_cyc_b,
                        we_cycle(15, PER_B, P_B, B_B) + 1);
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (ram_b[k] !== rom_b[k] ||
          ((k < we_q_b.size()) ? we_q_b[k] : -1) != we_cycle(k, PER_B, P_B, B_B)) begin
        n_err++; $display("FAIL full_word[%0d]: data %h at cycle %0d expected %h at %0d", k, ram_b[k],
                          (k < we_q_b.size()) ? we_q_b[k] : -1, rom_b[k], we_cycle(k, PER_B, P_B, B_B));
      end
    end
    n_cmp++;
    if (ram_addr_b !== 4'h0 || we_q_b.size() != 16 || {perr_b, ferr_b, busy_b} !== 3'b000) begin
      n_err++; $display("FAIL full_end_state: ram_addr %0d we %0d flags %b%b%b expected 0 16 000",
                        ram_addr_b, we_q_b.size(), perr_b, ferr_b, busy_b);
    end
  endtask

  initial begin
    start_a = 1'b0; mark_a = 1'b0; hold_low_a = 1'b0; wc_a = '0;
    start_b = 1'b0; mark_b = 1'b0; wc_b = '0;
    done_cnt_a = 0; done_cyc_a = -1; busy_seen_a = 1'b0; txlow_seen_a = 1'b0;
    done_cnt_b = 0; done_cyc_b = -1;
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = '0; rom_b[i] = '0;
    end
    test_reset();
    test_copy(1'b1, 4);
    for (int it = 0; it < 3; it++) test_copy(1'b0, int'($urandom_range(1, 16)));
    test_copy(1'b0, 16);
    test_zero_count();
    test_parity_err();
    test_frame_err();
    test_idle_glitch();
    test_full_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
